booth_mul_arbiter: RTL and testbench

//  Shares one pipelined radix-8 Booth multiplier (signed NxN -> 2N) among NREQ requesters.

---
 rtl/booth_arb_pkg.sv | 18 +
 rtl/booth_mul_arbiter_rr_pick.sv | 45 ++++
 rtl/booth_mul_arbiter.sv | 164 ++++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_arb_pkg.sv
// ---------------------------------------------------------------------------
// booth_arb_pkg
//   Shared constants and helpers for the Booth multiplier arbiter and for the
//   multiplier wrapper it drives. MUL_LAT_DEF must match the latency of the
//   multiplier instance the arbiter feeds.
// ---------------------------------------------------------------------------
package booth_arb_pkg;

    localparam int N_DEF       = 32;  // operand width
    localparam int NREQ_DEF    = 4;   // requester count
    localparam int MUL_LAT_DEF = 3;   // multiplier latency in cycles

    // Requester id width. Floors at 1 so a degenerate count still yields a legal vector.
    function automatic int idw_f(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/booth_mul_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. The search starts at ptr_i+1 (mod NREQ)
//   and the first set request wins.
// Ports
//   req_i  in  NREQ  request vector
//   ptr_i  in  IDW   index of the previous winner
//   gnt_o  out NREQ  one-hot grant (all zero if no request)
//   idx_o  out IDW   encoded winner index (0 if no request)
//   any_o  out 1     at least one request present
// ---------------------------------------------------------------------------
module rr_pick
    import booth_arb_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int IDW  = idw_f(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    logic found;
    int   j;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        found = 1'b0;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[j]) begin
                gnt_o[j] = 1'b1;
                idx_o    = IDW'(j);
                found    = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// ---------------------------------------------------------------------------
// booth_mul_arbiter
//   Shares one pipelined signed NxN multiplier among NREQ requesters. A
//   round-robin grant launches at most one operand pair per cycle. A tag
//   pipeline tracks the requester id alongside the multiplier latency, so each
//   product returns with its owner's id.
//   Optional build macro BOOTH_ARB_PERF_EN adds saturating per-requester grant
//   counters and a stall counter.
// Ports
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous active-high reset
//   req_valid    in   NREQ    per-requester operand pair valid
//   req_ready    out  NREQ    one-hot grant (combinational)
//   req_a/req_b  in   NREQ*N  packed operands, requester i at [i*N +: N]
//   mul_a/mul_b  out  N       registered multiplier operands (0 when idle)
//   mul_prod     in   2N      product, valid MUL_LAT cycles after mul_a/mul_b
//   rsp_valid    out  1       one-cycle product pulse
//   rsp_id       out  IDW     requester id of rsp_prod
//   rsp_prod     out  2N      registered copy of mul_prod
//   busy         out  1       launch this cycle or a tag still in flight
//   perf_grants  out  NREQ*32 (BOOTH_ARB_PERF_EN) per-requester transfer count
//   perf_stall   out  32      (BOOTH_ARB_PERF_EN) cycles with a waiting requester
// ---------------------------------------------------------------------------
module booth_mul_arbiter
    import booth_arb_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int NREQ    = NREQ_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*N-1:0]         req_a,
    input  logic [NREQ*N-1:0]         req_b,
    output logic [N-1:0]              mul_a,
    output logic [N-1:0]              mul_b,
    input  logic [2*N-1:0]            mul_prod,
    output logic                      rsp_valid,
    output logic [idw_f(NREQ)-1:0]    rsp_id,
    output logic [2*N-1:0]            rsp_prod,
`ifdef BOOTH_ARB_PERF_EN
    output logic [NREQ*32-1:0]        perf_grants,
    output logic [31:0]               perf_stall,
`endif
    output logic                      busy
);

    localparam int IDW = idw_f(NREQ);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  win_idx;
    logic            win_any;
    logic            xfer;
    logic            inflight;

    logic [IDW-1:0]  ptr_q,   ptr_d;
    logic [N-1:0]    mul_a_q, mul_a_d;
    logic [N-1:0]    mul_b_q, mul_b_d;
    tag_t            tag_q [MUL_LAT+1];
    tag_t            tag_d;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [2*N-1:0]  rsp_prod_q;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    // Grants are suppressed during reset, so no transfer can slip in while state is cleared.
    assign req_ready = rst ? '0 : gnt;
    assign xfer      = win_any & ~rst;

    // Launch decode. The pointer only moves on a transfer, so idle cycles do not rotate priority.
    always_comb begin
        ptr_d   = ptr_q;
        mul_a_d = '0;
        mul_b_d = '0;
        tag_d   = '0;
        if (xfer) begin
            ptr_d     = win_idx;
            mul_a_d   = req_a[int'(win_idx)*N +: N];
            mul_b_d   = req_b[int'(win_idx)*N +: N];
            tag_d.vld = 1'b1;
            tag_d.id  = win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
            ptr_q       <= IDW'(NREQ - 1);
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_prod_q  <= '0;
            // NOTE: the tag pipe is a short flop chain, not a RAM. Every stage is reset so that products in flight are dropped.
            for (int k = 0; k <= MUL_LAT; k++) tag_q[k] <= '0;
        end else begin
            ptr_q    <= ptr_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            tag_q[0] <= tag_d;
            for (int k = 1; k <= MUL_LAT; k++) tag_q[k] <= tag_q[k-1];
            // Tag stage MUL_LAT lines up with mul_prod for the launch made MUL_LAT cycles ago.
            rsp_valid_q <= tag_q[MUL_LAT].vld;
            rsp_id_q    <= tag_q[MUL_LAT].id;
            rsp_prod_q  <= mul_prod;
        end
    end

    always_comb begin
        inflight = 1'b0;
        for (int k = 0; k <= MUL_LAT; k++) inflight = inflight | tag_q[k].vld;
    end

    assign busy      = xfer | inflight;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_prod  = rsp_prod_q;

`ifdef BOOTH_ARB_PERF_EN
    logic [31:0] grants_q [NREQ];
    logic [31:0] stall_q;
    logic        stall_any;

    // One stall count per cycle, no matter how many requesters are waiting.
    assign stall_any = |(req_valid & ~req_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) grants_q[i] <= '0;
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (xfer && win_idx == IDW'(i) && grants_q[i] != '1)
                    grants_q[i] <= grants_q[i] + 32'd1;
            end
            if (stall_any && stall_q != '1) stall_q <= stall_q + 32'd1;
        end
    end

    always_comb begin
        perf_grants = '0;
        for (int i = 0; i < NREQ; i++) perf_grants[i*32 +: 32] = grants_q[i];
    end

    assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_booth_mul_arbiter
//   Directed bench for booth_mul_arbiter (N=32, NREQ=4, MUL_LAT=3). A
//   behavioural MUL_LAT-stage multiplier stands in for the shared instance.
//   Define BOOTH_ARB_PERF_EN to also exercise the performance counters.
// ---------------------------------------------------------------------------
module tb_booth_mul_arbiter;

    localparam int N       = 32;
    localparam int NREQ    = 4;
    localparam int MUL_LAT = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*N-1:0]    req_a;
    logic [NREQ*N-1:0]    req_b;
    logic [N-1:0]         mul_a;
    logic [N-1:0]         mul_b;
    logic [2*N-1:0]       mul_prod;
    logic                 rsp_valid;
    logic [1:0]           rsp_id;
    logic [2*N-1:0]       rsp_prod;
    logic                 busy;
`ifdef BOOTH_ARB_PERF_EN
    logic [NREQ*32-1:0]   perf_grants;
    logic [31:0]          perf_stall;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    booth_mul_arbiter #(.N(N), .NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_prod    (mul_prod),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_prod    (rsp_prod),
`ifdef BOOTH_ARB_PERF_EN
        .perf_grants (perf_grants),
        .perf_stall  (perf_stall),
`endif
        .busy        (busy)
    );

    // Behavioural shared multiplier: product appears MUL_LAT cycles after operands change.
    logic [2*N-1:0] mp [MUL_LAT];
    always @(posedge clk) begin
        mp[0] <= longint'($signed(mul_a)) * longint'($signed(mul_b));
        for (int k = 1; k < MUL_LAT; k++) mp[k] <= mp[k-1];
    end
    assign mul_prod = mp[MUL_LAT-1];

    task automatic apply_reset(input int cycles);
        rst       = 1'b1;
        req_valid = '0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '1;
        req_b     = '1;
        #1;
        tests_run++;
        if (req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_ready_during_rst: got %b expected 0000", req_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || mul_a !== 32'd0 || mul_b !== 32'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: rsp_valid=%b mul_a=%h mul_b=%h busy=%b expected 0/0/0/0",
                     rsp_valid, mul_a, mul_b, busy);
        end
        tests_run++;
        if (rsp_id !== 2'd0 || rsp_prod !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_rsp_regs: rsp_id=%0d rsp_prod=%h expected 0/0", rsp_id, rsp_prod);
        end
        req_valid = '0;
        rst       = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || mul_a !== 32'd0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold cycle %0d: ready=%b rsp_valid=%b mul_a=%h busy=%b expected 0000/0/0/0",
                         c, req_ready, rsp_valid, mul_a, busy);
            end
        end
    endtask

    task automatic test_single();
        req_a[2*N +: N] = 32'(-7);
        req_b[2*N +: N] = 32'd9;
        req_valid       = 4'b0100;
        #1;
        tests_run++;
        if (req_ready !== 4'b0100 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_grant: ready=%b busy=%b expected 0100/1", req_ready, busy);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        tests_run++;
        if (mul_a !== 32'hFFFF_FFF9 || mul_b !== 32'd9) begin
            tests_failed++;
            $display("FAIL single_launch: mul_a=%h mul_b=%h expected fffffff9/00000009", mul_a, mul_b);
        end
        for (int k = 1; k <= MUL_LAT + 2; k++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (k == MUL_LAT + 1) begin
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_prod !== 64'hFFFF_FFFF_FFFF_FFC1) begin
                    tests_failed++;
                    $display("FAIL single_rsp: valid=%b id=%0d prod=%h expected 1/2/ffffffffffffffc1",
                             rsp_valid, rsp_id, rsp_prod);
                end
            end else if (rsp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL single_rsp_timing k=%0d: rsp_valid=%b expected 0", k, rsp_valid);
            end
        end
    endtask

    task automatic test_fairness();
        logic [63:0] exp_prod;
        int          r;
        apply_reset(2);
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = 32'(i + 1);
            req_b[i*N +: N] = 32'(-(i + 1));
        end
        for (int t = 0; t < 8 + MUL_LAT + 3; t++) begin
            req_valid = (t < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (t < 8) begin
                tests_run++;
                if (req_ready !== (4'b0001 << (t % 4))) begin
                    tests_failed++;
                    $display("FAIL fair_grant t=%0d: got %b expected %b", t, req_ready, 4'b0001 << (t % 4));
                end
            end
            r = t - MUL_LAT - 2;
            tests_run++;
            if (r >= 0 && r < 8) begin
                exp_prod = -longint'(((r % 4) + 1) * ((r % 4) + 1));
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(r % 4) || rsp_prod !== exp_prod) begin
                    tests_failed++;
                    $display("FAIL fair_rsp r=%0d: valid=%b id=%0d prod=%h expected 1/%0d/%h",
                             r, rsp_valid, rsp_id, rsp_prod, r % 4, exp_prod);
                end
            end else if (rsp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL fair_idle t=%0d: rsp_valid=%b expected 0", t, rsp_valid);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Back-to-back grants to a single requester, using the signed operand extremes.
    task automatic test_back_to_back();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [63:0] ep [3];
        int          r;
        va = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        vb = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        ep = '{64'h4000_0000_0000_0000, 64'hC000_0000_8000_0000, 64'h0000_0000_8000_0000};
        for (int t = 0; t < 3 + MUL_LAT + 3; t++) begin
            if (t < 3) begin
                req_valid   = 4'b0001;
                req_a[0 +: N] = va[t];
                req_b[0 +: N] = vb[t];
            end else begin
                req_valid = 4'b0000;
            end
            #1;
            if (t < 3) begin
                tests_run++;
                if (req_ready !== 4'b0001) begin
                    tests_failed++;
                    $display("FAIL b2b_grant t=%0d: got %b expected 0001", t, req_ready);
                end
            end
            r = t - MUL_LAT - 2;
            tests_run++;
            if (r >= 0 && r < 3) begin
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_prod !== ep[r]) begin
                    tests_failed++;
                    $display("FAIL b2b_rsp r=%0d: valid=%b id=%0d prod=%h expected 1/0/%h",
                             r, rsp_valid, rsp_id, rsp_prod, ep[r]);
                end
            end else if (rsp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_idle t=%0d: rsp_valid=%b expected 0", t, rsp_valid);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_midflight();
        for (int t = 0; t < 3; t++) begin
            req_a[t*N +: N] = 32'(t + 10);
            req_b[t*N +: N] = 32'd2;
            req_valid       = 4'b0001 << t;
            #1;
            tests_run++;
            if (req_ready !== (4'b0001 << t)) begin
                tests_failed++;
                $display("FAIL midrst_grant t=%0d: got %b expected %b", t, req_ready, 4'b0001 << t);
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_busy: got %b expected 0", busy);
        end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (rsp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL midrst_discard cycle %0d: rsp_valid=%b expected 0", c, rsp_valid);
            end
        end
        // Recovery: first post-reset transfer returns with the normal latency.
        req_a[3*N +: N] = 32'd5;
        req_b[3*N +: N] = 32'(-3);
        req_valid       = 4'b1000;
        #1;
        tests_run++;
        if (req_ready !== 4'b1000) begin
            tests_failed++;
            $display("FAIL midrst_regrant: got %b expected 1000", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        for (int k = 1; k <= MUL_LAT + 2; k++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (k == MUL_LAT + 1) begin
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_prod !== 64'hFFFF_FFFF_FFFF_FFF1) begin
                    tests_failed++;
                    $display("FAIL midrst_recover: valid=%b id=%0d prod=%h expected 1/3/fffffffffffffff1",
                             rsp_valid, rsp_id, rsp_prod);
                end
            end else if (rsp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL midrst_recover_timing k=%0d: rsp_valid=%b expected 0", k, rsp_valid);
            end
        end
    endtask

`ifdef BOOTH_ARB_PERF_EN
    task automatic test_perf();
        logic [31:0] sum;
        apply_reset(2);
        for (int t = 0; t < 6; t++) begin
            req_valid = 4'b0111;
            #1;
            tests_run++;
            if (req_ready !== (4'b0001 << (t % 3))) begin
                tests_failed++;
                $display("FAIL perf_grant t=%0d: got %b expected %b", t, req_ready, 4'b0001 << (t % 3));
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        #1;
        sum = perf_grants[0 +: 32] + perf_grants[32 +: 32] + perf_grants[64 +: 32] + perf_grants[96 +: 32];
        tests_run++;
        if (sum !== 32'd6 || perf_stall !== 32'd6) begin
            tests_failed++;
            $display("FAIL perf_totals: grants=%0d stall=%0d expected 6/6", sum, perf_stall);
        end
        for (int i = 0; i < NREQ; i++) begin
            tests_run++;
            if (perf_grants[i*32 +: 32] !== ((i < 3) ? 32'd2 : 32'd0)) begin
                tests_failed++;
                $display("FAIL perf_grant_count[%0d]: got %0d expected %0d",
                         i, perf_grants[i*32 +: 32], (i < 3) ? 2 : 0);
            end
        end
        repeat (MUL_LAT + 3) @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        test_reset();
        test_single();
        test_fairness();
        test_back_to_back();
        test_reset_midflight();
`ifdef BOOTH_ARB_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
